sseg_scan_decoder: RTL and testbench

Receive-side counterpart of the 3-digit multiplexed seven-segment driver. It samples the active-low anode and segment lines (an, sseg), waits for each anode dwell to become stable, and decodes the segment pattern back into the 5-bit display code, decimal-point bit and enable bit. Completed 3-digit frames are published as one atomic update. It sits on the board-level loopback and self-test path, and in benches as a display monitor.

---
 rtl/sseg_scan_decoder_if.sv | 24 ++
 rtl/sseg_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_decoder_if.sv
// Signal bundle between a multiplexed seven-segment line source and the scan decoder.
// master drives the anode/segment lines, slave returns the decoded frame and status pulses.
interface sseg_scan_decoder_if;
  logic [2:0] an_in;
  logic [7:0] sseg_in;
  logic [4:0] hex2;
  logic [4:0] hex1;
  logic [4:0] hex0;
  logic [2:0] dp_out;
  logic [2:0] en_out;
  logic       frame_valid;
  logic       code_err;
  logic       scan_err;

  modport master (
    output an_in, sseg_in,
    input  hex2, hex1, hex0, dp_out, en_out, frame_valid, code_err, scan_err
  );

  modport slave (
    input  an_in, sseg_in,
    output hex2, hex1, hex0, dp_out, en_out, frame_valid, code_err, scan_err
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Samples active-low anode/segment lines, captures each stable digit dwell once,
// decodes it back to a 5-bit code and publishes complete 3-digit frames atomically.
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input logic           clk,
  input logic           reset,
  sseg_scan_decoder_if.slave bus
);
  localparam logic [CNT_W-1:0] CAPTURE_AT = CNT_W'(STABLE_CYCLES - 1);
  // Synchronizers start at "all lines off" so reset release looks like an idle gap.
  localparam logic [10:0]      IDLE_LINES = 11'h7FF;

  logic [10:0]      r_sync1;
  logic [10:0]      r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_captured;

  logic [4:0] r_stage_code [3];
  logic       r_stage_dp   [3];
  logic       r_stage_en   [3];
  logic [2:0] r_mask;

  logic [4:0] r_hex [3];
  logic [2:0] r_dp_out;
  logic [2:0] r_en_out;
  logic       r_frame_valid;
  logic       r_code_err;
  logic       r_scan_err;

  logic       w_change;
  logic       w_capture;
  logic [2:0] w_an;
  logic       w_one_low;
  logic       w_multi_low;
  logic [2:0] w_sel;
  logic [2:0] w_mask_base;
  logic [4:0] w_code;
  logic       w_en;
  logic       w_undef;
  logic       w_dp;

  assign w_change  = (r_sync1 != r_sync2);
  assign w_capture = (r_cnt == CAPTURE_AT) && !r_captured;
  assign w_an      = r_sync2[10:8];
  assign w_dp      = ~r_sync2[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= IDLE_LINES;
      r_sync2    <= IDLE_LINES;
      r_cnt      <= '0;
      r_captured <= 1'b0;
    end else begin
      r_sync1 <= {bus.an_in, bus.sseg_in};
      r_sync2 <= r_sync1;
      if (w_change) begin
        r_cnt      <= '0;
        r_captured <= 1'b0;
      end else begin
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_capture) begin
          r_captured <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_one_low   = (w_an == 3'b110) || (w_an == 3'b101) || (w_an == 3'b011);
    w_multi_low = ($countones(w_an) <= 1);
    w_sel       = w_one_low ? ~w_an : 3'b000;
  end

  always_comb begin
    w_code  = 5'h1F;
    w_en    = 1'b1;
    w_undef = 1'b0;
    case (r_sync2[6:0])
      7'b0000001: w_code = 5'h00;
      7'b1001111: w_code = 5'h01;
      7'b0010010: w_code = 5'h02;
      7'b0000110: w_code = 5'h03;
      7'b1001100: w_code = 5'h04;
      7'b0100100: w_code = 5'h05;
      7'b0100000: w_code = 5'h06;
      7'b0001111: w_code = 5'h07;
      7'b0000000: w_code = 5'h08;
      7'b0000100: w_code = 5'h09;
      7'b0001000: w_code = 5'h0A;
      7'b1100000: w_code = 5'h0B;
      7'b0110001: w_code = 5'h0C;
      7'b1000010: w_code = 5'h0D;
      7'b0110000: w_code = 5'h0E;
      7'b0111000: w_code = 5'h0F;
      7'b1000001: w_code = 5'h10;
      7'b1111110: w_code = 5'h11;
      7'b0001001: w_code = 5'h13;
      7'b1100010: w_code = 5'h14;
      7'b0011100: w_code = 5'h15;
      7'b1111001: w_code = 5'h16;
      7'b1001001: w_code = 5'h17;
      7'b1111100: w_code = 5'h18;
      7'b1111111: begin
        w_code = 5'h12;
        w_en   = 1'b0;
      end
      default: w_undef = 1'b1;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_stage_code[gi] <= '0;
          r_stage_dp[gi]   <= 1'b0;
          r_stage_en[gi]   <= 1'b0;
        end else if (w_capture && w_sel[gi]) begin
          r_stage_code[gi] <= w_code;
          r_stage_dp[gi]   <= w_dp;
          r_stage_en[gi]   <= w_en;
        end
      end
    end
  endgenerate

  // A full mask publishes one cycle after the last slot lands, then restarts collection.
  assign w_mask_base = (r_mask == 3'b111) ? 3'b000 : r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask        <= 3'b000;
      r_hex[0]      <= 5'h12;
      r_hex[1]      <= 5'h12;
      r_hex[2]      <= 5'h12;
      r_dp_out      <= 3'b000;
      r_en_out      <= 3'b000;
      r_frame_valid <= 1'b0;
      r_code_err    <= 1'b0;
      r_scan_err    <= 1'b0;
    end else begin
      r_mask        <= w_mask_base | (w_capture ? w_sel : 3'b000);
      r_frame_valid <= (r_mask == 3'b111);
      r_code_err    <= w_capture && w_one_low && w_undef;
      r_scan_err    <= w_capture && w_multi_low;
      if (r_mask == 3'b111) begin
        for (int i = 0; i < 3; i++) begin
          r_hex[i]    <= r_stage_code[i];
          r_dp_out[i] <= r_stage_dp[i];
          r_en_out[i] <= r_stage_en[i];
        end
      end
    end
  end

  assign bus.hex0        = r_hex[0];
  assign bus.hex1        = r_hex[1];
  assign bus.hex2        = r_hex[2];
  assign bus.dp_out      = r_dp_out;
  assign bus.en_out      = r_en_out;
  assign bus.frame_valid = r_frame_valid;
  assign bus.code_err    = r_code_err;
  assign bus.scan_err    = r_scan_err;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: a dwell-length model predicts every output each cycle,
// and literal expectations pin the decoded frames of each scenario.
module tb_sseg_scan_decoder;
  localparam int STABLE = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   fv_cnt;
  int   ce_cnt;
  int   se_cnt;

  sseg_scan_decoder_if bus_if ();

  sseg_scan_decoder #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyph table: entry k is the a..g pattern shown for COD_TAB[k].
  localparam logic [6:0] SEG_TAB [0:23] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1000001, 7'b1111110,
    7'b0001001, 7'b1100010, 7'b0011100, 7'b1111001, 7'b1001001, 7'b1111100};
  localparam logic [4:0] COD_TAB [0:23] = '{
    5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B,
    5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_decode(input logic [6:0] seg, output logic [4:0] code,
                              output logic en, output logic undef);
    code  = 5'h1F;
    en    = 1'b1;
    undef = 1'b1;
    if (seg == 7'h7F) begin
      code  = 5'h12;
      en    = 1'b0;
      undef = 1'b0;
    end
    for (int k = 0; k < 24; k++) begin
      if (SEG_TAB[k] == seg) begin
        code  = COD_TAB[k];
        undef = 1'b0;
      end
    end
  endtask

  typedef struct packed {
    logic       v;
    logic [2:0] an;
    logic [7:0] sg;
  } ev_t;

  logic [10:0] m_prev;
  int          m_run;
  ev_t         m_d1, m_d2;
  logic [4:0]  m_code [3];
  logic        m_dp   [3];
  logic        m_en   [3];
  logic [2:0]  m_mask;
  logic        m_pub;
  logic [4:0]  e_hex  [3];
  logic [2:0]  e_dp, e_en;
  logic        e_fv, e_ce, e_se;

  task automatic model_apply(input ev_t ev);
    int         zeros;
    int         slot;
    logic [4:0] code;
    logic       en, undef;
    zeros = $countones(~ev.an);
    if (zeros == 1) begin
      slot = (ev.an[0] == 1'b0) ? 0 : ((ev.an[1] == 1'b0) ? 1 : 2);
      model_decode(ev.sg[6:0], code, en, undef);
      m_code[slot] = code;
      m_en[slot]   = en;
      m_dp[slot]   = ~ev.sg[7];
      m_mask[slot] = 1'b1;
      if (undef) e_ce = 1'b1;
      if (m_mask == 3'b111) m_pub = 1'b1;
    end else if (zeros >= 2) begin
      e_se = 1'b1;
    end
  endtask

  // Model: a dwell seen on STABLE consecutive edges takes effect 2 edges later, publish 1 more.
  always @(posedge clk) begin
    logic [10:0] cur;
    if (reset) begin
      m_prev = 11'h7FF;
      m_run  = 2;
      m_d1   = '0;
      m_d2   = '0;
      m_mask = 3'b000;
      m_pub  = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_code[i] = 5'h00;
        m_dp[i]   = 1'b0;
        m_en[i]   = 1'b0;
        e_hex[i]  = 5'h12;
      end
      e_dp = 3'b000;
      e_en = 3'b000;
      e_fv = 1'b0;
      e_ce = 1'b0;
      e_se = 1'b0;
    end else begin
      cur  = {bus_if.an_in, bus_if.sseg_in};
      e_fv = 1'b0;
      e_ce = 1'b0;
      e_se = 1'b0;
      if (m_pub) begin
        for (int i = 0; i < 3; i++) begin
          e_hex[i] = m_code[i];
          e_dp[i]  = m_dp[i];
          e_en[i]  = m_en[i];
        end
        e_fv   = 1'b1;
        m_mask = 3'b000;
        m_pub  = 1'b0;
      end
      if (m_d2.v) model_apply(m_d2);
      m_d2 = m_d1;
      if (cur == m_prev) begin
        if (m_run < 1000000) m_run++;
      end else begin
        m_prev = cur;
        m_run  = 1;
      end
      m_d1.v  = (m_run == STABLE);
      m_d1.an = cur[10:8];
      m_d1.sg = cur[7:0];
    end
    #1;
    chk("hex0", 32'(bus_if.hex0), 32'(e_hex[0]));
    chk("hex1", 32'(bus_if.hex1), 32'(e_hex[1]));
    chk("hex2", 32'(bus_if.hex2), 32'(e_hex[2]));
    chk("dp_out", 32'(bus_if.dp_out), 32'(e_dp));
    chk("en_out", 32'(bus_if.en_out), 32'(e_en));
    chk("frame_valid", 32'(bus_if.frame_valid), 32'(e_fv));
    chk("code_err", 32'(bus_if.code_err), 32'(e_ce));
    chk("scan_err", 32'(bus_if.scan_err), 32'(e_se));
    if (bus_if.frame_valid === 1'b1) begin
      fv_cnt++;
      $display("frame: hex2=%0h hex1=%0h hex0=%0h dp=%b en=%b", bus_if.hex2, bus_if.hex1,
               bus_if.hex0, bus_if.dp_out, bus_if.en_out);
    end
    if (bus_if.code_err === 1'b1) begin
      ce_cnt++;
      $display("code_err pulse at %0t", $time);
    end
    if (bus_if.scan_err === 1'b1) begin
      se_cnt++;
      $display("scan_err pulse at %0t", $time);
    end
  end

  task automatic dwell(input logic [2:0] a, input logic [7:0] s, input int n);
    @(negedge clk);
    bus_if.an_in   = a;
    bus_if.sseg_in = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic chk_frame(input string tag, input logic [4:0] h2, input logic [4:0] h1,
                           input logic [4:0] h0, input logic [2:0] dp, input logic [2:0] en);
    chk({tag, ".hex2"}, 32'(bus_if.hex2), 32'(h2));
    chk({tag, ".hex1"}, 32'(bus_if.hex1), 32'(h1));
    chk({tag, ".hex0"}, 32'(bus_if.hex0), 32'(h0));
    chk({tag, ".dp"}, 32'(bus_if.dp_out), 32'(dp));
    chk({tag, ".en"}, 32'(bus_if.en_out), 32'(en));
  endtask

  initial begin
    int fv0, ce0, se0;
    checks         = 0;
    errors         = 0;
    fv_cnt         = 0;
    ce_cnt         = 0;
    se_cnt         = 0;
    reset          = 1'b1;
    bus_if.an_in   = 3'b111;
    bus_if.sseg_in = 8'hFF;
    repeat (3) @(negedge clk);
    chk_frame("reset", 5'h12, 5'h12, 5'h12, 3'b000, 3'b000);
    reset = 1'b0;
    dwell(3'b111, 8'hFF, 20);

    // Basic scan at a long dwell.
    fv0 = fv_cnt;
    dwell(3'b110, 8'b1_0000110, 256);
    dwell(3'b101, 8'b0_0010010, 256);
    dwell(3'b011, 8'b1_1001111, 256);
    dwell(3'b111, 8'hFF, 20);
    chk("scan.frames", 32'(fv_cnt - fv0), 32'd1);
    chk_frame("scan", 5'h01, 5'h02, 5'h03, 3'b010, 3'b111);

    // Glitch shorter than the stability window must not count as digit 1.
    fv0 = fv_cnt;
    dwell(3'b110, 8'b1_0100100, 64);
    dwell(3'b101, 8'b1_0000000, 10);
    dwell(3'b011, 8'b1_0000100, 64);
    dwell(3'b111, 8'hFF, 20);
    chk("glitch.no_frame", 32'(fv_cnt - fv0), 32'd0);
    dwell(3'b101, 8'b0_0001000, 64);
    dwell(3'b111, 8'hFF, 20);
    chk("glitch.frames", 32'(fv_cnt - fv0), 32'd1);
    chk_frame("glitch", 5'h09, 5'h0A, 5'h05, 3'b010, 3'b111);

    // Blank and undefined glyphs.
    fv0 = fv_cnt;
    ce0 = ce_cnt;
    dwell(3'b110, 8'hFF, 64);
    dwell(3'b101, 8'b1_1010101, 64);
    dwell(3'b011, 8'b1_1001001, 64);
    dwell(3'b111, 8'hFF, 20);
    chk("blank.frames", 32'(fv_cnt - fv0), 32'd1);
    chk("blank.code_err", 32'(ce_cnt - ce0), 32'd1);
    chk_frame("blank", 5'h17, 5'h1F, 5'h12, 3'b000, 3'b110);

    // Multi-low anode fault keeps the partial frame; an idle gap does nothing.
    fv0 = fv_cnt;
    se0 = se_cnt;
    dwell(3'b110, 8'b1_0000001, 64);
    dwell(3'b101, 8'b1_1000001, 64);
    dwell(3'b100, 8'b1_0000001, 64);
    dwell(3'b111, 8'hFF, 64);
    chk("anode.scan_err", 32'(se_cnt - se0), 32'd1);
    chk("anode.no_frame", 32'(fv_cnt - fv0), 32'd0);
    dwell(3'b011, 8'b1_1111110, 64);
    dwell(3'b111, 8'hFF, 20);
    chk("anode.frames", 32'(fv_cnt - fv0), 32'd1);
    chk_frame("anode", 5'h11, 5'h10, 5'h00, 3'b000, 3'b111);

    // Reset with two digits staged discards the partial frame.
    dwell(3'b110, 8'b1_0001001, 64);
    dwell(3'b101, 8'b1_1100010, 64);
    @(negedge clk);
    reset          = 1'b1;
    bus_if.an_in   = 3'b111;
    bus_if.sseg_in = 8'hFF;
    repeat (3) @(negedge clk);
    chk_frame("midreset", 5'h12, 5'h12, 5'h12, 3'b000, 3'b000);
    reset = 1'b0;
    fv0   = fv_cnt;
    dwell(3'b111, 8'hFF, 40);
    chk("midreset.no_frame", 32'(fv_cnt - fv0), 32'd0);
    chk_frame("midreset.hold", 5'h12, 5'h12, 5'h12, 3'b000, 3'b000);
    dwell(3'b110, 8'b1_0011100, 64);
    dwell(3'b101, 8'b1_1111001, 64);
    dwell(3'b011, 8'b1_1111100, 64);
    dwell(3'b111, 8'hFF, 20);
    chk("midreset.frames", 32'(fv_cnt - fv0), 32'd1);
    chk_frame("midreset.new", 5'h18, 5'h16, 5'h15, 3'b000, 3'b111);

    // Repeated digit 0 overwrites its slot without completing the frame early.
    fv0 = fv_cnt;
    dwell(3'b110, 8'b1_0100100, 64);
    dwell(3'b110, 8'b0_0000100, 64);
    dwell(3'b101, 8'b1_0110001, 64);
    dwell(3'b011, 8'b1_1000010, 64);
    dwell(3'b111, 8'hFF, 20);
    chk("repeat.frames", 32'(fv_cnt - fv0), 32'd1);
    chk_frame("repeat", 5'h0D, 5'h0C, 5'h09, 3'b001, 3'b111);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
